imem_loader: RTL

Writer-side companion to the instruction memory of the ARM single-cycle model. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into a writable instruction RAM at word-aligned byte addresses, using the same A[5:2] indexing the fetch side reads with. The processor is held in reset until a load session completes successfully.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_byte_packer.sv | 57 +++++
 rtl/imem_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader,
// its writable imem and its testbench.
package imem_loader_pkg;

  localparam int DEPTH_LOG2_DEF = 4;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CSUM = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles four accepted stream bytes into a little-endian word and raises
// a registered one-cycle strobe in the cycle after the fourth byte.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o,
  output logic              last_lane_o
);

  logic [1:0]        lane_q, lane_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              done_q, done_d;

  // New bytes enter at the top so that lane 0 ends up in bits [7:0].
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    word_d  = word_q;
    done_d  = 1'b0;
    if (clear_i) begin
      lane_d = 2'd0;
    end else if (accept_i) begin
      shift_d = {byte_i, shift_q[WORD_W-1:BYTE_W]};
      lane_d  = lane_q + 2'd1;
      if (lane_q == 2'd3) begin
        word_d = {byte_i, shift_q[WORD_W-1:BYTE_W]};
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q  <= 2'd0;
      shift_q <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

  assign word_o      = word_q;
  assign word_done_o = done_q;
  assign last_lane_o = (lane_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction RAM; holds the CPU in reset until a
// session completes. Define IMEM_LOADER_CHECKSUM_EN for the trailing XOR byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [DEPTH_LOG2:0] word_count,
  input  logic                byte_valid,
  input  logic [BYTE_W-1:0]   byte_data,
  output logic                byte_ready,
  output logic                we,
  output logic [WORD_W-1:0]   wa,
  output logic [WORD_W-1:0]   wd,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_e              state_q, state_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic [DEPTH_LOG2:0] words_q, words_d;
  logic [WORD_W-1:0]   wa_q, wa_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cpu_q, cpu_d;
  logic                clear;
  logic                accept, pack_accept, last_lane, word_full, last_word;
  logic [DEPTH_LOG2:0] target;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   csum_q, csum_d;
  logic                err_q, err_d;
`endif

  assign accept      = byte_valid & ready_q;
  assign pack_accept = accept & (state_q == LOAD);
  assign target      = (count_q == '0) ? FULL_COUNT : count_q;
  assign word_full   = pack_accept & last_lane;
  assign last_word   = word_full & ((words_q + (DEPTH_LOG2+1)'(1)) == target);

  imem_byte_packer u_packer (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .clear_i     (clear),
    .accept_i    (pack_accept),
    .byte_i      (byte_data),
    .word_o      (wd),
    .word_done_o (we),
    .last_lane_o (last_lane)
  );

  // The write address is captured with the fourth byte so it lines up with
  // the packer's registered write strobe in the following cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    words_d = words_q;
    wa_d    = wa_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cpu_d   = cpu_q;
    clear   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = word_count;
          words_d = '0;
          cpu_d   = 1'b1;
          busy_d  = 1'b1;
          ready_d = 1'b1;
          clear   = 1'b1;
          state_d = LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (pack_accept) csum_d = csum_q ^ byte_data;
`endif
        if (word_full) begin
          wa_d    = WORD_W'({words_q[DEPTH_LOG2-1:0], 2'b00});
          words_d = words_q + (DEPTH_LOG2+1)'(1);
        end
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          ready_d = 1'b0;
          state_d = FIN;
`endif
        end
      end
      CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) begin
          err_d   = (byte_data != csum_q);
          ready_d = 1'b0;
          state_d = FIN;
        end
`else
        state_d = IDLE;
`endif
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
        cpu_d   = err_q;
`else
        cpu_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      words_q <= '0;
      wa_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cpu_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      words_q <= words_d;
      wa_q    <= wa_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cpu_q   <= cpu_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign byte_ready = ready_q;
  assign wa         = wa_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cpu_reset  = cpu_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule
